// File: rtl/mux_scan_ctrl_pkg.sv
// rtl/mux_scan_ctrl_pkg.sv - shared encodings, widths and helpers for the mux scan sequencer
package mux_scan_ctrl_pkg;

   localparam int N_CH  = 4;
   localparam int SEL_W = 2;
   localparam int CNT_W = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [N_CH-1:0]  frame_t;

   function automatic logic frame_parity(input frame_t f);
      return ^f;
   endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - frame output handshake bundle; frame_par exists only with MUX_SCAN_PARITY_EN
interface mux_scan_ctrl_if;
   import mux_scan_ctrl_pkg::*;

   frame_t frame;
   logic   frame_valid;
   logic   frame_ready;
`ifdef MUX_SCAN_PARITY_EN
   logic   frame_par;

   modport master (output frame, output frame_valid, output frame_par, input frame_ready);
   modport slave  (input frame, input frame_valid, input frame_par, output frame_ready);
`else
   modport master (output frame, output frame_valid, input frame_ready);
   modport slave  (input frame, input frame_valid, output frame_ready);
`endif

endinterface

// File: rtl/mux_scan_timer.sv
// rtl/mux_scan_timer.sv - settle counter with clear/enable; done flags the last settle cycle
module mux_scan_timer
   import mux_scan_ctrl_pkg::*;
#(
   parameter int SETTLE_CYC = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = en && (cnt_q == CNT_W'(SETTLE_CYC - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - walks a 4:1 mux select, samples M per channel and offers a 4-bit frame
// Optional frame parity output enabled by MUX_SCAN_PARITY_EN.
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
#(
   parameter int SETTLE_CYC = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   cont,
   input  logic                   abort,
   input  logic                   m_in,
   output logic [SEL_W-1:0]       sel,
   output logic                   busy,
   mux_scan_ctrl_if.master        fo
);

   logic [1:0] state_q, state_d;
   sel_t       sel_q, sel_d;
   logic [2:0] asm_q, asm_d;
   frame_t     frame_q, frame_d;
   logic       valid_q, valid_d;
   logic       tmr_clr;
   logic       tmr_en;
   logic       tmr_done;

   assign tmr_en  = (state_q == ST_SETTLE);
   assign tmr_clr = (state_q != ST_SETTLE) || abort;

   mux_scan_timer #(
      .SETTLE_CYC (SETTLE_CYC)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .done  (tmr_done)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      asm_d   = asm_q;
      frame_d = frame_q;
      valid_d = valid_q;
      // abort outranks every other input once a scan is underway
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         sel_d   = '0;
         asm_d   = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_SETTLE;
                  sel_d   = '0;
               end
            end
            ST_SETTLE: begin
               if (tmr_done) begin
                  state_d = ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (sel_q != sel_t'(N_CH - 1)) begin
                  asm_d[sel_q] = m_in;
                  sel_d        = sel_q + sel_t'(1);
                  state_d      = ST_SETTLE;
               end else begin
                  frame_d = {m_in, asm_q};
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (fo.frame_ready) begin
                  valid_d = 1'b0;
                  if (cont || start) begin
                     state_d = ST_SETTLE;
                     sel_d   = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         asm_q   <= '0;
         frame_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         asm_q   <= asm_d;
         frame_q <= frame_d;
         valid_q <= valid_d;
      end
   end

`ifdef MUX_SCAN_PARITY_EN
   logic par_q;
   logic par_d;

   assign par_d = frame_parity(frame_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign fo.frame_par = par_q;
`endif

   assign sel            = sel_q;
   assign busy           = (state_q != ST_IDLE);
   assign fo.frame       = frame_q;
   assign fo.frame_valid = valid_q;

endmodule
